// File: rtl/cdb_arbiter_pkg.sv
// Shared widths, bus-source encoding and sizing helpers for the CDB arbiter slice.
package cdb_arbiter_pkg;

    localparam int unsigned DATA_LEN = 32;
    localparam int unsigned ROB_LEN  = 4;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// In-order holding FIFO for one CDB requester: push/pop/count, async reset, sync flush.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [W-1:0]                wdata_i,
    output logic [W-1:0]                rdata_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = ptr_width(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Wrap explicitly so non-power-of-two depths stay modulo DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between the ALU and the LSB load path.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_LEN,
    parameter int unsigned ROB_W  = ROB_LEN,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              clear,
    input  logic              alu_flag,
    input  logic [DATA_W-1:0] alu_val,
    input  logic [DATA_W-1:0] alu_jumpto,
    input  logic [ROB_W-1:0]  alu_robpos,
    output logic              alu_stall,
    input  logic              lsb_flag,
    input  logic [DATA_W-1:0] lsb_val,
    input  logic [ROB_W-1:0]  lsb_robpos,
    output logic              lsb_stall,
    output logic              cdb_flag,
    output logic [DATA_W-1:0] cdb_val,
    output logic [DATA_W-1:0] cdb_jumpto,
    output logic [ROB_W-1:0]  cdb_robpos,
    output logic              cdb_src
);

    localparam int unsigned ALU_W = 2 * DATA_W + ROB_W;
    localparam int unsigned LSB_W = DATA_W + ROB_W;
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [CNT_W-1:0]  alu_cnt, lsb_cnt;
    logic [ALU_W-1:0]  alu_head;
    logic [LSB_W-1:0]  lsb_head;
    logic              alu_acc, lsb_acc;
    logic              alu_cand_v, lsb_cand_v;
    logic              grant_alu, grant_lsb;
    logic              alu_push, alu_pop, lsb_push, lsb_pop;
    logic              fifo_flush;
    logic [DATA_W-1:0] alu_c_val, alu_c_jmp, lsb_c_val;
    logic [ROB_W-1:0]  alu_c_rob, lsb_c_rob;

    cdb_src_e          prio_q, prio_d;
    cdb_src_e          src_q, src_d;
    logic              flag_q, flag_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [DATA_W-1:0] jmp_q, jmp_d;
    logic [ROB_W-1:0]  rob_q, rob_d;

    // Stall depends on registered count only, so a full FIFO refuses input even while popping.
    assign alu_stall = !ready || (alu_cnt == CNT_W'(DEPTH));
    assign lsb_stall = !ready || (lsb_cnt == CNT_W'(DEPTH));
    assign alu_acc   = alu_flag && !alu_stall;
    assign lsb_acc   = lsb_flag && !lsb_stall;

    always_comb begin
        {alu_c_val, alu_c_jmp, alu_c_rob} = (alu_cnt != '0) ? alu_head
                                            : {alu_val, alu_jumpto, alu_robpos};
        {lsb_c_val, lsb_c_rob} = (lsb_cnt != '0) ? lsb_head : {lsb_val, lsb_robpos};
        alu_cand_v = (alu_cnt != '0) || alu_acc;
        lsb_cand_v = (lsb_cnt != '0) || lsb_acc;

        grant_alu = 1'b0;
        grant_lsb = 1'b0;
        if (ready && !clear) begin
            if (alu_cand_v && (!lsb_cand_v || prio_q == CDB_SRC_ALU)) grant_alu = 1'b1;
            else if (lsb_cand_v)                                       grant_lsb = 1'b1;
        end

        // A granted bypass input goes straight to the bus and never enters its FIFO.
        alu_pop    = grant_alu && (alu_cnt != '0);
        lsb_pop    = grant_lsb && (lsb_cnt != '0);
        alu_push   = alu_acc && !clear && !(grant_alu && (alu_cnt == '0));
        lsb_push   = lsb_acc && !clear && !(grant_lsb && (lsb_cnt == '0));
        fifo_flush = ready && clear;

        prio_d = prio_q;
        if (grant_alu)      prio_d = CDB_SRC_LSB;
        else if (grant_lsb) prio_d = CDB_SRC_ALU;

        flag_d = grant_alu || grant_lsb;
        val_d  = val_q;
        jmp_d  = jmp_q;
        rob_d  = rob_q;
        src_d  = src_q;
        if (grant_alu) begin
            val_d = alu_c_val;
            jmp_d = alu_c_jmp;
            rob_d = alu_c_rob;
            src_d = CDB_SRC_ALU;
        end else if (grant_lsb) begin
            val_d = lsb_c_val;
            jmp_d = '0;
            rob_d = lsb_c_rob;
            src_d = CDB_SRC_LSB;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_q <= CDB_SRC_ALU;
            flag_q <= 1'b0;
            val_q  <= '0;
            jmp_q  <= '0;
            rob_q  <= '0;
            src_q  <= CDB_SRC_ALU;
        end else begin
            prio_q <= prio_d;
            flag_q <= flag_d;
            val_q  <= val_d;
            jmp_q  <= jmp_d;
            rob_q  <= rob_d;
            src_q  <= src_d;
        end
    end

    cdb_fifo #(.W(ALU_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (fifo_flush),
        .push_i  (alu_push),
        .pop_i   (alu_pop),
        .wdata_i ({alu_val, alu_jumpto, alu_robpos}),
        .rdata_o (alu_head),
        .count_o (alu_cnt)
    );

    cdb_fifo #(.W(LSB_W), .DEPTH(DEPTH)) u_lsb_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .flush_i (fifo_flush),
        .push_i  (lsb_push),
        .pop_i   (lsb_pop),
        .wdata_i ({lsb_val, lsb_robpos}),
        .rdata_o (lsb_head),
        .count_o (lsb_cnt)
    );

    assign cdb_flag   = flag_q;
    assign cdb_val    = val_q;
    assign cdb_jumpto = jmp_q;
    assign cdb_robpos = rob_q;
    assign cdb_src    = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-level reference model, decoupled bus monitor.
module tb_cdb_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned RW    = 4;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [DW-1:0] val;
        logic [DW-1:0] jmp;
        logic [RW-1:0] rob;
        logic          src;
    } res_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ready = 1'b0;
    logic          clear = 1'b0;
    logic          alu_flag = 1'b0;
    logic [DW-1:0] alu_val = '0;
    logic [DW-1:0] alu_jumpto = '0;
    logic [RW-1:0] alu_robpos = '0;
    logic          alu_stall;
    logic          lsb_flag = 1'b0;
    logic [DW-1:0] lsb_val = '0;
    logic [RW-1:0] lsb_robpos = '0;
    logic          lsb_stall;
    logic          cdb_flag;
    logic [DW-1:0] cdb_val;
    logic [DW-1:0] cdb_jumpto;
    logic [RW-1:0] cdb_robpos;
    logic          cdb_src;

    int   errors = 0;
    int   checks = 0;
    res_t aq[$];
    res_t lq[$];
    res_t sb[$];
    bit   mprio = 1'b0;
    bit   exp_flag = 1'b0;
    res_t last = '{default: '0};

    cdb_arbiter #(.DATA_W(DW), .ROB_W(RW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ready      (ready),
        .clear      (clear),
        .alu_flag   (alu_flag),
        .alu_val    (alu_val),
        .alu_jumpto (alu_jumpto),
        .alu_robpos (alu_robpos),
        .alu_stall  (alu_stall),
        .lsb_flag   (lsb_flag),
        .lsb_val    (lsb_val),
        .lsb_robpos (lsb_robpos),
        .lsb_stall  (lsb_stall),
        .cdb_flag   (cdb_flag),
        .cdb_val    (cdb_val),
        .cdb_jumpto (cdb_jumpto),
        .cdb_robpos (cdb_robpos),
        .cdb_src    (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each source is a queue of results not yet on the bus; one grant per cycle.
    task automatic step(input logic af, input logic [DW-1:0] av, input logic [DW-1:0] aj,
                        input logic [RW-1:0] ar, input logic lf, input logic [DW-1:0] lv,
                        input logic [RW-1:0] lr, input logic rdy, input logic clr);
        res_t e;
        bit   ga, gl;
        @(negedge clk);
        alu_flag = af; alu_val = av; alu_jumpto = aj; alu_robpos = ar;
        lsb_flag = lf; lsb_val = lv; lsb_robpos = lr;
        ready = rdy; clear = clr;
        #1;
        chk("alu_stall", alu_stall, !rdy || aq.size() == DEPTH);
        chk("lsb_stall", lsb_stall, !rdy || lq.size() == DEPTH);
        if (!rdy) begin
            exp_flag = 1'b0;
        end else if (clr) begin
            aq.delete();
            lq.delete();
            exp_flag = 1'b0;
        end else begin
            if (af && aq.size() < DEPTH) begin
                e.val = av; e.jmp = aj; e.rob = ar; e.src = 1'b0;
                aq.push_back(e);
            end
            if (lf && lq.size() < DEPTH) begin
                e.val = lv; e.jmp = '0; e.rob = lr; e.src = 1'b1;
                lq.push_back(e);
            end
            ga = aq.size() > 0 && (lq.size() == 0 || mprio == 1'b0);
            gl = !ga && lq.size() > 0;
            if (ga) begin
                sb.push_back(aq.pop_front());
                mprio = 1'b1;
            end else if (gl) begin
                sb.push_back(lq.pop_front());
                mprio = 1'b0;
            end
            exp_flag = ga || gl;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, '0, 0, '0, '0, 1, 0);
    endtask

    task automatic both(input int n);
        for (int i = 0; i < n; i++)
            step(1, $urandom, $urandom, RW'(i), 1, $urandom, RW'(i + 8), 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        ready = 1'b1; clear = 1'b0; alu_flag = 1'b0; lsb_flag = 1'b0;
        aq.delete(); lq.delete(); sb.delete();
        mprio = 1'b0; exp_flag = 1'b0; last = '{default: '0};
        #1;
        chk("rst_flag", cdb_flag, 1'b0);
        chk("rst_payload", {cdb_val, cdb_jumpto, cdb_robpos, cdb_src}, '0);
        chk("rst_stalls", {alu_stall, lsb_stall}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin : monitor
        res_t e;
        forever begin
            @(posedge clk);
            #1;
            chk("cdb_flag", cdb_flag, exp_flag);
            if (cdb_flag === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: got robpos %0h src %0b expected no result at %0t",
                             cdb_robpos, cdb_src, $time);
                end else begin
                    e = sb.pop_front();
                    chk("bus_payload", {cdb_val, cdb_jumpto, cdb_robpos, cdb_src},
                        {e.val, e.jmp, e.rob, e.src});
                    last = e;
                end
            end else begin
                chk("bus_hold", {cdb_val, cdb_jumpto, cdb_robpos, cdb_src},
                    {last.val, last.jmp, last.rob, last.src});
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin : driver
        do_reset();
        step(1, 32'h5, 32'h104, 4'd3, 0, '0, '0, 1, 0);
        idle(2);

        do_reset();
        step(1, 32'h11, 32'h200, 4'd1, 1, 32'h22, 4'd2, 1, 0);
        idle(3);

        do_reset();
        both(8);
        idle(5);

        do_reset();
        for (int i = 0; i < 3; i++) step(0, '0, '0, '0, 1, $urandom, RW'(i + 4), 1, 0);
        step(1, $urandom, $urandom, 4'd9, 0, '0, '0, 1, 0);
        idle(6);

        do_reset();
        both(4);
        step(1, $urandom, $urandom, 4'd14, 1, $urandom, 4'd15, 1, 1);
        idle(4);

        do_reset();
        both(3);
        for (int i = 0; i < 3; i++)
            step(1, $urandom, $urandom, 4'd12, 1, $urandom, 4'd13, 0, 0);
        idle(6);

        both(2);
        do_reset();
        idle(3);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 60, $urandom, $urandom, RW'($urandom),
                 $urandom_range(0, 99) < 55, $urandom, RW'($urandom),
                 $urandom_range(0, 99) < 88, $urandom_range(0, 99) < 3);
        idle(8);
        chk("bus_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
